mips_decode_exec_unit: RTL and testbench
========================================

Name: mips_decode_exec_unit

Overview:
- Single-stage MIPS decode-and-execute slice. It merges the main control decoder, the ALU-control decoder and the 32-bit ALU.
- The EX/MEM pipeline register sits on its outputs.
- It takes opcode, immediate, register operands and destination fields from the ID stage.
- It produces the ALU result and zero flag, plus the control bits needed by the MEM and WB stages, one cycle later.

Parameters:
None. Datapath is fixed at 32 bits, register indices at 5 bits.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26]
imm  in  16  instruction[15:0]; funct = imm[5:0]
rt  in  5  instruction[20:16]
rd  in  5  instruction[15:11]
rs_data  in  32  ALU operand A
rt_data  in  32  register rt value; ALU operand B when alusrc=0; store data
flush  in  1  synchronous clear of the output register
regdst  out  1  combinational decode
alusrc  out  1  combinational decode
aluop  out  2  combinational decode
aluctl  out  4  combinational ALU control
alu_result_q  out  32  registered ALU result
zero_q  out  1  registered zero flag
wrreg_q  out  5  registered destination register
store_data_q  out  32  registered rt_data
regwrite_q, memtoreg_q, memread_q, memwrite_q, branch_q  out  1 each  registered control

Behaviour:
- Main decode (combinational), fields listed as regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop:
  - 000000 R-type: 1,0,0,1,0,0,0,10
  - 100011 lw: 0,1,1,1,1,0,0,00
  - 101011 sw: 0,1,0,0,0,1,0,00
  - 000100 beq: 0,0,0,0,0,0,1,01
  - 001000 addi: 0,1,0,1,0,0,0,00
  - Any other opcode: all zero (NOP).
- ALU control:
  - aluop 00 -> 0010 (add).
  - aluop 01 -> 0110 (sub).
  - aluop 10 decodes funct: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 101010 slt 0111; 100111 nor 1100; any other funct -> 1111.
  - aluop 11 -> 1111.
- Operands:
  - seimm = sign-extend(imm) to 32 bits.
  - B = alusrc ? seimm : rt_data; A = rs_data.
- ALU (combinational):
  - 0000 A&B; 0001 A|B; 0010 A+B mod 2^32; 0110 A-B mod 2^32.
  - 0111: 1 if A<B as signed two's complement, else 0.
  - 1100: ~(A|B).
  - Any other ctl: result 0.
  - zero = (result == 0).
  - No overflow detection or trap.
- Destination: wrreg = regdst ? rd : rt.
- Output register:
  - On each rising clk with rst_n=1 and flush=0, captures alu result, zero, wrreg, rt_data, regwrite, memtoreg, memread, memwrite and branch into the *_q outputs.
  - Latency is exactly 1 cycle from input to *_q. Every cycle loads; there is no hold or handshake.
- flush=1 at a rising edge loads all *_q outputs with 0 (bubble), overriding the new inputs.
- rst_n=0 immediately clears all *_q outputs to 0, independent of clk. The first capture happens on the first rising edge after rst_n deasserts.
- Reset dominates flush.
- Combinational outputs (regdst, alusrc, aluop, aluctl) follow the inputs regardless of reset.
- A flushed or NOP instruction must never assert regwrite_q, memread_q, memwrite_q or branch_q.

Test Plan:
- Reset: assert rst_n=0 mid-cycle after loading non-zero values -> all *_q outputs become 0 immediately, without waiting for a clock edge.
- R-type add:
  - Stimulus: opcode=000000, imm=0x0020, rd=3, rs_data=5, rt_data=7.
  - Response, one edge later: alu_result_q=12, zero_q=0, wrreg_q=3, regwrite_q=1, regdst=1, aluctl=0010.
- R-type sub, slt, nor:
  - sub with A=7, B=7 -> alu_result_q=0, zero_q=1.
  - slt with A=0xFFFFFFFF, B=1 -> alu_result_q=1.
  - nor with A=0, B=0 -> alu_result_q=0xFFFFFFFF.
- lw:
  - Stimulus: opcode=100011, imm=0xFFFC, rs_data=0x100, rt=9.
  - Response: alu_result_q=0xFC, wrreg_q=9, memread_q=1, memtoreg_q=1, regwrite_q=1, alusrc=1.
  - sw with rt_data=0xDEADBEEF -> store_data_q=0xDEADBEEF, memwrite_q=1, regwrite_q=0.
- beq:
  - rs_data=rt_data=0x55 -> branch_q=1, zero_q=1, aluctl=0110.
  - rt_data=0x54 -> zero_q=0.
- Flush and illegal opcodes:
  - lw inputs with flush=1 -> all *_q outputs=0 after the edge.
  - opcode=111111 -> all decode outputs 0 and no control bit set in *_q.
  - R-type funct=000000 -> aluctl=1111, alu_result_q=0.

Source files
------------

// File: rtl/mips_decode_exec_unit.sv
// MIPS decode-and-execute slice: main control decode, ALU control decode and
// 32-bit ALU, with the EX/MEM pipeline register on the outputs.
module mips_decode_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [15:0] imm,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        regdst,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic [3:0]  aluctl,
  output logic [31:0] alu_result_q,
  output logic        zero_q,
  output logic [4:0]  wrreg_q,
  output logic [31:0] store_data_q,
  output logic        regwrite_q,
  output logic        memtoreg_q,
  output logic        memread_q,
  output logic        memwrite_q,
  output logic        branch_q
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_SLT = 6'b101010,
    FN_NOR = 6'b100111
  } funct_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_NOR  = 4'b1100,
    ALU_NONE = 4'b1111
  } alu_ctl_e;

  logic        memtoreg, regwrite, memread, memwrite, branch;
  logic [31:0] seimm, b_op, alu_result;
  logic [4:0]  wrreg;

  logic [31:0] alu_result_d, store_data_d;
  logic        zero_d, regwrite_d, memtoreg_d, memread_d, memwrite_d, branch_d;
  logic [4:0]  wrreg_d;

  always_comb begin
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    branch   = 1'b0;
    aluop    = 2'b00;
    case (opcode)
      OP_RTYPE: begin regdst = 1'b1; regwrite = 1'b1; aluop = 2'b10; end
      OP_LW:    begin alusrc = 1'b1; memtoreg = 1'b1; regwrite = 1'b1; memread = 1'b1; end
      OP_SW:    begin alusrc = 1'b1; memwrite = 1'b1; end
      OP_BEQ:   begin branch = 1'b1; aluop = 2'b01; end
      OP_ADDI:  begin alusrc = 1'b1; regwrite = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    aluctl = ALU_NONE;
    case (aluop)
      2'b00: aluctl = ALU_ADD;
      2'b01: aluctl = ALU_SUB;
      2'b10: begin
        case (imm[5:0])
          FN_ADD:  aluctl = ALU_ADD;
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_SLT:  aluctl = ALU_SLT;
          FN_NOR:  aluctl = ALU_NOR;
          default: aluctl = ALU_NONE;
        endcase
      end
      default: aluctl = ALU_NONE;
    endcase
  end

  assign seimm = {{16{imm[15]}}, imm};
  assign b_op  = alusrc ? seimm : rt_data;
  assign wrreg = regdst ? rd : rt;

  always_comb begin
    alu_result = '0;
    case (aluctl)
      ALU_AND: alu_result = rs_data & b_op;
      ALU_OR:  alu_result = rs_data | b_op;
      ALU_ADD: alu_result = rs_data + b_op;
      ALU_SUB: alu_result = rs_data - b_op;
      ALU_SLT: alu_result = {31'b0, $signed(rs_data) < $signed(b_op)};
      ALU_NOR: alu_result = ~(rs_data | b_op);
      default: alu_result = '0;
    endcase
  end

  // A flush inserts a bubble: every field, not just the control bits, goes to 0.
  always_comb begin
    alu_result_d = alu_result;
    zero_d       = (alu_result == '0);
    wrreg_d      = wrreg;
    store_data_d = rt_data;
    regwrite_d   = regwrite;
    memtoreg_d   = memtoreg;
    memread_d    = memread;
    memwrite_d   = memwrite;
    branch_d     = branch;
    if (flush) begin
      alu_result_d = '0;
      zero_d       = 1'b0;
      wrreg_d      = '0;
      store_data_d = '0;
      regwrite_d   = 1'b0;
      memtoreg_d   = 1'b0;
      memread_d    = 1'b0;
      memwrite_d   = 1'b0;
      branch_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      wrreg_q      <= '0;
      store_data_q <= '0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      branch_q     <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      wrreg_q      <= wrreg_d;
      store_data_q <= store_data_d;
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      branch_q     <= branch_d;
    end
  end

endmodule

// File: tb/tb_mips_decode_exec_unit.sv
// Bench for mips_decode_exec_unit: directed vector table, reset/flush/latency
// sequences, and random instructions checked against a behavioural model.
module tb_mips_decode_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [15:0] imm;
  logic [4:0]  rt, rd;
  logic [31:0] rs_data, rt_data;
  logic        flush;
  logic        regdst, alusrc;
  logic [1:0]  aluop;
  logic [3:0]  aluctl;
  logic [31:0] alu_result_q, store_data_q;
  logic        zero_q, regwrite_q, memtoreg_q, memread_q, memwrite_q, branch_q;
  logic [4:0]  wrreg_q;

  int n_cmp = 0;
  int n_bad = 0;

  mips_decode_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .imm(imm), .rt(rt), .rd(rd),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .aluctl(aluctl),
    .alu_result_q(alu_result_q), .zero_q(zero_q), .wrreg_q(wrreg_q),
    .store_data_q(store_data_q), .regwrite_q(regwrite_q), .memtoreg_q(memtoreg_q),
    .memread_q(memread_q), .memwrite_q(memwrite_q), .branch_q(branch_q)
  );

  always #5 clk = ~clk;

  // ctl packs {regwrite, memtoreg, memread, memwrite, branch}
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [15:0] imm;
    logic [4:0]  rt, rd;
    logic [31:0] rs, rtd;
    logic        fl;
    logic [31:0] res;
    logic        z;
    logic [4:0]  wr;
    logic [31:0] st;
    logic [4:0]  ctl;
    logic        rdst, asrc;
    logic [1:0]  aop;
    logic [3:0]  actl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [5:0] op, logic [15:0] im, logic [4:0] t,
                              logic [4:0] d, logic [31:0] rs, logic [31:0] rtd, logic fl,
                              logic [31:0] res, logic z, logic [4:0] wr, logic [31:0] st,
                              logic [4:0] ctl, logic rdst, logic asrc, logic [1:0] aop,
                              logic [3:0] actl);
    vec_t v;
    v.name = name; v.op = op; v.imm = im; v.rt = t; v.rd = d; v.rs = rs; v.rtd = rtd;
    v.fl = fl; v.res = res; v.z = z; v.wr = wr; v.st = st; v.ctl = ctl;
    v.rdst = rdst; v.asrc = asrc; v.aop = aop; v.actl = actl;
    return v;
  endfunction

  // Behavioural reference: instruction semantics by mnemonic, plain integer arithmetic.
  function automatic vec_t model(logic [5:0] op, logic [15:0] im, logic [4:0] t, logic [4:0] d,
                                 logic [31:0] rs, logic [31:0] rtd, logic fl);
    vec_t v;
    string mn;
    longint sa, sb;
    logic [31:0] b;
    v.name = "rand"; v.op = op; v.imm = im; v.rt = t; v.rd = d; v.rs = rs; v.rtd = rtd; v.fl = fl;
    v.rdst = 0; v.asrc = 0; v.aop = 2'd0; v.ctl = 5'b00000;
    if (op == 6'd0)            begin v.rdst = 1; v.aop = 2'd2; v.ctl = 5'b10000; end
    else if (op == 6'b100011)  begin v.asrc = 1; v.ctl = 5'b11100; end
    else if (op == 6'b101011)  begin v.asrc = 1; v.ctl = 5'b00010; end
    else if (op == 6'b000100)  begin v.aop = 2'd1; v.ctl = 5'b00001; end
    else if (op == 6'b001000)  begin v.asrc = 1; v.ctl = 5'b10000; end
    if (v.aop == 2'd0) mn = "add";
    else if (v.aop == 2'd1) mn = "sub";
    else case (im[5:0])
      6'd32: mn = "add";  6'd34: mn = "sub";  6'd36: mn = "and";
      6'd37: mn = "or";   6'd42: mn = "slt";  6'd39: mn = "nor";
      default: mn = "bad";
    endcase
    case (mn)
      "add": v.actl = 4'd2;  "sub": v.actl = 4'd6;  "and": v.actl = 4'd0;
      "or":  v.actl = 4'd1;  "slt": v.actl = 4'd7;  "nor": v.actl = 4'd12;
      default: v.actl = 4'd15;
    endcase
    sb = $signed(im);
    b = v.asrc ? 32'(sb) : rtd;
    sa = $signed(rs);
    sb = $signed(b);
    case (mn)
      "add": v.res = 32'((longint'(rs) + longint'(b)) % 64'h1_0000_0000);
      "sub": v.res = 32'((longint'(rs) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      "and": v.res = rs & b;
      "or":  v.res = rs | b;
      "slt": v.res = (sa < sb) ? 32'd1 : 32'd0;
      "nor": v.res = ~(rs | b);
      default: v.res = 32'd0;
    endcase
    v.z  = (v.res == 32'd0);
    v.wr = v.rdst ? d : t;
    v.st = rtd;
    if (fl) begin
      v.res = 0; v.z = 0; v.wr = 0; v.st = 0; v.ctl = 0;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    opcode = v.op; imm = v.imm; rt = v.rt; rd = v.rd;
    rs_data = v.rs; rt_data = v.rtd; flush = v.fl;
  endtask

  task automatic chk_comb(input vec_t v);
    chk({v.name, ".regdst"}, 32'(regdst), 32'(v.rdst));
    chk({v.name, ".alusrc"}, 32'(alusrc), 32'(v.asrc));
    chk({v.name, ".aluop"},  32'(aluop),  32'(v.aop));
    chk({v.name, ".aluctl"}, 32'(aluctl), 32'(v.actl));
  endtask

  task automatic chk_q(input vec_t v);
    chk({v.name, ".alu_result_q"}, alu_result_q, v.res);
    chk({v.name, ".zero_q"},       32'(zero_q), 32'(v.z));
    chk({v.name, ".wrreg_q"},      32'(wrreg_q), 32'(v.wr));
    chk({v.name, ".store_data_q"}, store_data_q, v.st);
    chk({v.name, ".ctl_q"},
        32'({regwrite_q, memtoreg_q, memread_q, memwrite_q, branch_q}), 32'(v.ctl));
  endtask

  task automatic chk_all_q_zero(input string nm);
    chk({nm, ".alu_result_q"}, alu_result_q, 32'd0);
    chk({nm, ".store_data_q"}, store_data_q, 32'd0);
    chk({nm, ".misc_q"},
        32'({zero_q, wrreg_q, regwrite_q, memtoreg_q, memread_q, memwrite_q, branch_q}), 32'd0);
  endtask

  // Drive at negedge, check decode, then check the register after the next rising edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    #1 chk_comb(v);
    @(posedge clk);
    #1 chk_q(v);
  endtask

  initial begin
    vec_t v, a, b;
    rst_n = 1'b0; flush = 1'b0; opcode = '0; imm = '0; rt = '0; rd = '0;
    rs_data = '0; rt_data = '0;

    //        name       op         imm       rt  rd  rs            rtd           fl res           z  wr  st            ctl       rdst asrc aop    actl
    vecs.push_back(mk("radd",  6'h00, 16'h0020, 4,  3,  32'd5,        32'd7,        0, 32'd12,       0, 3,  32'd7,        5'b10000, 1, 0, 2'b10, 4'b0010));
    vecs.push_back(mk("rsub",  6'h00, 16'h0022, 4,  3,  32'd7,        32'd7,        0, 32'd0,        1, 3,  32'd7,        5'b10000, 1, 0, 2'b10, 4'b0110));
    vecs.push_back(mk("rslt",  6'h00, 16'h002A, 4,  3,  32'hFFFFFFFF, 32'd1,        0, 32'd1,        0, 3,  32'd1,        5'b10000, 1, 0, 2'b10, 4'b0111));
    vecs.push_back(mk("rnor",  6'h00, 16'h0027, 4,  3,  32'd0,        32'd0,        0, 32'hFFFFFFFF, 0, 3,  32'd0,        5'b10000, 1, 0, 2'b10, 4'b1100));
    vecs.push_back(mk("rand_", 6'h00, 16'h0024, 1,  2,  32'h0000F0F0, 32'h0000FF00, 0, 32'h0000F000, 0, 2,  32'h0000FF00, 5'b10000, 1, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("ror",   6'h00, 16'h0025, 1,  2,  32'h0000F0F0, 32'h0000FF00, 0, 32'h0000FFF0, 0, 2,  32'h0000FF00, 5'b10000, 1, 0, 2'b10, 4'b0001));
    vecs.push_back(mk("lw",    6'h23, 16'hFFFC, 9,  31, 32'h100,      32'h12,       0, 32'hFC,       0, 9,  32'h12,       5'b11100, 0, 1, 2'b00, 4'b0010));
    vecs.push_back(mk("sw",    6'h2B, 16'h0008, 5,  0,  32'h200,      32'hDEADBEEF, 0, 32'h208,      0, 5,  32'hDEADBEEF, 5'b00010, 0, 1, 2'b00, 4'b0010));
    vecs.push_back(mk("beqeq", 6'h04, 16'h0003, 2,  0,  32'h55,       32'h55,       0, 32'd0,        1, 2,  32'h55,       5'b00001, 0, 0, 2'b01, 4'b0110));
    vecs.push_back(mk("beqne", 6'h04, 16'h0003, 2,  0,  32'h55,       32'h54,       0, 32'd1,        0, 2,  32'h54,       5'b00001, 0, 0, 2'b01, 4'b0110));
    vecs.push_back(mk("lwfl",  6'h23, 16'hFFFC, 9,  31, 32'h100,      32'h12,       1, 32'd0,        0, 0,  32'd0,        5'b00000, 0, 1, 2'b00, 4'b0010));
    vecs.push_back(mk("ill",   6'h3F, 16'h1234, 6,  2,  32'd10,       32'd20,       0, 32'd30,       0, 6,  32'd20,       5'b00000, 0, 0, 2'b00, 4'b0010));
    vecs.push_back(mk("fn0",   6'h00, 16'h0000, 1,  2,  32'd9,        32'd9,        0, 32'd0,        1, 2,  32'd9,        5'b10000, 1, 0, 2'b10, 4'b1111));
    vecs.push_back(mk("addin", 6'h08, 16'h8000, 7,  16, 32'd0,        32'd3,        0, 32'hFFFF8000, 0, 7,  32'd3,        5'b10000, 0, 1, 2'b00, 4'b0010));

    #12;
    chk_all_q_zero("reset0");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset mid-cycle after loading non-zero values.
    run_vec(vecs[6]);
    #2 rst_n = 1'b0;
    #1 chk_all_q_zero("async_rst");
    // Decode follows inputs during reset; reset dominates flush across an edge.
    drive(vecs[0]);
    flush = 1'b0;
    #1 chk_comb(vecs[0]);
    @(posedge clk);
    #1 chk_all_q_zero("rst_hold");
    flush = 1'b1;
    @(posedge clk);
    #1 chk_all_q_zero("rst_over_flush");
    @(negedge clk);
    rst_n = 1'b1;
    drive(vecs[7]);
    @(posedge clk);
    #1 chk_q(vecs[7]);

    // Back-to-back: every edge loads, latency exactly one cycle.
    a = vecs[0]; b = vecs[8];
    @(negedge clk); drive(a);
    @(posedge clk); #1 chk_q(a);
    @(negedge clk); drive(b);
    #1 chk_q(a);
    @(posedge clk); #1 chk_q(b);

    // Randomized instructions against the reference model.
    for (int unsigned k = 0; k < 400; k++) begin
      logic [5:0] op;
      logic [15:0] im;
      case ($urandom_range(0, 5))
        0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B;
        3: op = 6'h04; 4: op = 6'h08; default: op = 6'($urandom);
      endcase
      im = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0: im[5:0] = 6'd32; 1: im[5:0] = 6'd34; 2: im[5:0] = 6'd36;
          3: im[5:0] = 6'd37; 4: im[5:0] = 6'd42; default: im[5:0] = 6'd39;
        endcase
      end
      v = model(op, im, 5'($urandom), 5'($urandom),
                ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom),
                ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom),
                ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 9) == 0) v.rtd = v.rs;
      v = model(v.op, v.imm, v.rt, v.rd, v.rs, v.rtd, v.fl);
      run_vec(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
